// File: rtl/wbu.sv
// wbu - write-back unit, final pipeline stage.
//
// Accepts one retiring instruction per handshake from the load/store unit,
// commits it to the 32x32 GPR file and the four machine CSRs, resolves the
// next PC (including the ecall trap redirect through mtvec) and hands that
// PC to instruction fetch.  Also provides combinational GPR/CSR read ports
// for decode.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   wbu_receive_valid        retiring instruction valid (sampled in IDLE only)
//   wd, rd, reg_write_en     GPR write data / index / enable
//   csr_wd, csr_rd,
//   csreg_write_en           CSR write data / index / enable
//   ecall                    retiring instruction is ecall
//   pc, pc_next, instruction PC, upstream next PC, raw instruction
//   ifu_ready                fetch accepts the redirect
//   raddr1, raddr2, rdata1,
//   rdata2                   GPR read ports (x0 reads as zero)
//   csr_raddr, csr_rdata     CSR read port
//   wbu_send_valid, dnpc     next PC handshake to fetch
//   commit_valid, commit_pc,
//   commit_inst              retirement trace (one pulse per instruction)
//   wbu_state                high whenever the FSM is not IDLE

module wbu #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter logic [31:0] MSTATUS_RST = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wbu_receive_valid,
  input  logic [31:0] wd,
  input  logic [31:0] csr_wd,
  input  logic [4:0]  rd,
  input  logic [1:0]  csr_rd,
  input  logic        reg_write_en,
  input  logic        csreg_write_en,
  input  logic        ecall,
  input  logic [31:0] pc,
  input  logic [31:0] pc_next,
  input  logic [31:0] instruction,
  input  logic        ifu_ready,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  input  logic [1:0]  csr_raddr,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  output logic [31:0] csr_rdata,
  output logic        wbu_send_valid,
  output logic [31:0] dnpc,
  output logic [31:0] commit_pc,
  output logic [31:0] commit_inst,
  output logic        commit_valid,
  output logic        wbu_state
);

  localparam logic [1:0] CSR_MSTATUS = 2'd0;
  localparam logic [1:0] CSR_MTVEC   = 2'd1;
  localparam logic [1:0] CSR_MEPC    = 2'd2;
  localparam logic [1:0] CSR_MCAUSE  = 2'd3;

  localparam logic [31:0] CAUSE_ECALL_M = 32'd11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COMMIT = 2'd1,
    S_SEND   = 2'd2
  } state_e;

  state_e      state_q;

  // Instruction captured at the IDLE handshake
  logic [31:0] wd_q;
  logic [31:0] csr_wd_q;
  logic [4:0]  rd_q;
  logic [1:0]  csr_rd_q;
  logic        reg_we_q;
  logic        csr_we_q;
  logic        ecall_q;
  logic [31:0] pc_q;
  logic [31:0] pc_next_q;
  logic [31:0] inst_q;

  logic [31:0] dnpc_q;
  logic        send_valid_q;
  logic        commit_valid_q;
  logic        busy_q;

  // Architectural state
  logic [31:0] gpr_q [32];
  logic [31:0] csr_q [4];

  // Commit-stage decisions, only meaningful while in COMMIT
  logic [31:0] dnpc_d;
  logic        gpr_we_s;
  logic        csr_we_s;

  // Resolve redirect target and write qualifiers from the latched instruction
  always_comb begin
    dnpc_d   = pc_next_q;
    gpr_we_s = 1'b0;
    csr_we_s = 1'b0;
    if (ecall_q) begin
      // mtvec as it stands before this commit edge
      dnpc_d = csr_q[CSR_MTVEC];
    end else begin
      dnpc_d = pc_next_q;
    end
    // x0 is hardwired to zero, so writes to it are dropped
    gpr_we_s = reg_we_q && (rd_q != 5'd0);
    // ecall owns mepc/mcause this cycle; the instruction's own CSR write is dropped
    csr_we_s = csr_we_q && !ecall_q;
  end

  // Handshake FSM, instruction latch, register-file and CSR commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      wd_q           <= 32'd0;
      csr_wd_q       <= 32'd0;
      rd_q           <= 5'd0;
      csr_rd_q       <= 2'd0;
      reg_we_q       <= 1'b0;
      csr_we_q       <= 1'b0;
      ecall_q        <= 1'b0;
      pc_q           <= 32'd0;
      pc_next_q      <= 32'd0;
      inst_q         <= 32'd0;
      dnpc_q         <= RESET_PC;
      send_valid_q   <= 1'b0;
      commit_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        gpr_q[i] <= 32'd0;
      end
      csr_q[CSR_MSTATUS] <= MSTATUS_RST;
      csr_q[CSR_MTVEC]   <= 32'd0;
      csr_q[CSR_MEPC]    <= 32'd0;
      csr_q[CSR_MCAUSE]  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wbu_receive_valid) begin
            wd_q           <= wd;
            csr_wd_q       <= csr_wd;
            rd_q           <= rd;
            csr_rd_q       <= csr_rd;
            reg_we_q       <= reg_write_en;
            csr_we_q       <= csreg_write_en;
            ecall_q        <= ecall;
            pc_q           <= pc;
            pc_next_q      <= pc_next;
            inst_q         <= instruction;
            commit_valid_q <= 1'b1;
            busy_q         <= 1'b1;
            state_q        <= S_COMMIT;
          end else begin
            commit_valid_q <= 1'b0;
            state_q        <= S_IDLE;
          end
        end
        S_COMMIT: begin
          commit_valid_q <= 1'b0;
          dnpc_q         <= dnpc_d;
          send_valid_q   <= 1'b1;
          if (gpr_we_s) begin
            gpr_q[rd_q] <= wd_q;
          end
          if (ecall_q) begin
            csr_q[CSR_MEPC]   <= pc_q;
            csr_q[CSR_MCAUSE] <= CAUSE_ECALL_M;
          end else if (csr_we_s) begin
            csr_q[csr_rd_q] <= csr_wd_q;
          end
          state_q <= S_SEND;
        end
        S_SEND: begin
          // dnpc_q holds until fetch takes it
          if (ifu_ready) begin
            send_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end else begin
            state_q <= S_SEND;
          end
        end
        default: begin
          send_valid_q   <= 1'b0;
          commit_valid_q <= 1'b0;
          busy_q         <= 1'b0;
          state_q        <= S_IDLE;
        end
      endcase
    end
  end

  // Read ports see storage only; a same-cycle write is not forwarded
  assign rdata1    = (raddr1 == 5'd0) ? 32'd0 : gpr_q[raddr1];
  assign rdata2    = (raddr2 == 5'd0) ? 32'd0 : gpr_q[raddr2];
  assign csr_rdata = csr_q[csr_raddr];

  assign wbu_send_valid = send_valid_q;
  assign dnpc           = dnpc_q;
  assign commit_valid   = commit_valid_q;
  assign commit_pc      = pc_q;
  assign commit_inst    = inst_q;
  assign wbu_state      = busy_q;

endmodule

// File: tb/tb_wbu.sv
// Self-checking bench for wbu: scoreboard of expected retirements
// (pc, instruction, redirect target) pushed when an instruction is driven
// and popped when the unit reports the commit.
module tb_wbu;

  logic        clk;
  logic        rst;
  logic        wbu_receive_valid;
  logic [31:0] wd;
  logic [31:0] csr_wd;
  logic [4:0]  rd;
  logic [1:0]  csr_rd;
  logic        reg_write_en;
  logic        csreg_write_en;
  logic        ecall;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] instruction;
  logic        ifu_ready;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [1:0]  csr_raddr;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] csr_rdata;
  logic        wbu_send_valid;
  logic [31:0] dnpc;
  logic [31:0] commit_pc;
  logic [31:0] commit_inst;
  logic        commit_valid;
  logic        wbu_state;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] dnpc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        last_e;
  logic [31:0] m_mtvec;
  int          errors;
  int          checks;

  wbu dut (
    .clk               (clk),
    .rst               (rst),
    .wbu_receive_valid (wbu_receive_valid),
    .wd                (wd),
    .csr_wd            (csr_wd),
    .rd                (rd),
    .csr_rd            (csr_rd),
    .reg_write_en      (reg_write_en),
    .csreg_write_en    (csreg_write_en),
    .ecall             (ecall),
    .pc                (pc),
    .pc_next           (pc_next),
    .instruction       (instruction),
    .ifu_ready         (ifu_ready),
    .raddr1            (raddr1),
    .raddr2            (raddr2),
    .csr_raddr         (csr_raddr),
    .rdata1            (rdata1),
    .rdata2            (rdata2),
    .csr_rdata         (csr_rdata),
    .wbu_send_valid    (wbu_send_valid),
    .dnpc              (dnpc),
    .commit_pc         (commit_pc),
    .commit_inst       (commit_inst),
    .commit_valid      (commit_valid),
    .wbu_state         (wbu_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one instruction (call just after a negedge) and record its expectation
  task automatic drive_instr(input logic [4:0] r, input logic [31:0] w,
                             input logic [1:0] cr, input logic [31:0] cw,
                             input logic rwe, input logic cwe, input logic ec,
                             input logic [31:0] p, input logic [31:0] pn,
                             input logic [31:0] ins);
    exp_t e;
    rd = r; wd = w; csr_rd = cr; csr_wd = cw;
    reg_write_en = rwe; csreg_write_en = cwe; ecall = ec;
    pc = p; pc_next = pn; instruction = ins;
    wbu_receive_valid = 1'b1;
    e.pc   = p;
    e.inst = ins;
    e.dnpc = ec ? m_mtvec : pn;
    sb_q.push_back(e);
    if (!ec && cwe && (cr == 2'd1)) m_mtvec = cw;
  endtask

  // Follow a driven instruction through COMMIT and SEND, checking against the scoreboard
  task automatic complete_retire();
    int n;
    @(negedge clk);
    wbu_receive_valid = 1'b0;
    n = 0;
    while (!commit_valid && n < 4) begin @(negedge clk); n++; end
    checks++;
    if (!commit_valid || sb_q.size() == 0) begin
      errors++;
      $display("FAIL commit_timeout: commit_valid=%b queued=%0d, required commit", commit_valid, sb_q.size());
      return;
    end
    last_e = sb_q.pop_front();
    checks++;
    if (commit_pc !== last_e.pc || commit_inst !== last_e.inst) begin
      errors++;
      $display("FAIL commit_trace: pc=%h inst=%h, required pc=%h inst=%h", commit_pc, commit_inst, last_e.pc, last_e.inst);
    end
    checks++;
    if (wbu_state !== 1'b1) begin
      errors++;
      $display("FAIL state_commit: wbu_state=%b, required 1", wbu_state);
    end
    @(negedge clk);
    checks++;
    if (wbu_send_valid !== 1'b1 || commit_valid !== 1'b0) begin
      errors++;
      $display("FAIL send_timing: send_valid=%b commit_valid=%b, required 1/0", wbu_send_valid, commit_valid);
    end
    checks++;
    if (dnpc !== last_e.dnpc) begin
      errors++;
      $display("FAIL dnpc: got %h, required %h", dnpc, last_e.dnpc);
    end
    if (ifu_ready) begin
      @(negedge clk);
      checks++;
      if (wbu_send_valid !== 1'b0 || wbu_state !== 1'b0) begin
        errors++;
        $display("FAIL back_to_idle: send_valid=%b state=%b, required 0/0", wbu_send_valid, wbu_state);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    csr_raddr = 2'd0;
    raddr1 = 5'd5;
    @(negedge clk);
    checks++;
    if (wbu_send_valid !== 1'b0 || commit_valid !== 1'b0 || wbu_state !== 1'b0 ||
        dnpc !== 32'h8000_0000 || commit_pc !== 32'd0 || commit_inst !== 32'd0) begin
      errors++;
      $display("FAIL reset_idle: sv=%b cv=%b st=%b dnpc=%h cpc=%h cinst=%h, required 0 0 0 80000000 0 0",
               wbu_send_valid, commit_valid, wbu_state, dnpc, commit_pc, commit_inst);
    end
    checks++;
    if (csr_rdata !== 32'h0000_1800 || rdata1 !== 32'd0) begin
      errors++;
      $display("FAIL reset_storage: mstatus=%h x5=%h, required 00001800 0", csr_rdata, rdata1);
    end
    // Reset while an instruction sits in SEND
    ifu_ready = 1'b0;
    drive_instr(5'd5, 32'hAAAA_5555, 2'd1, 32'h1111_0000, 1'b1, 1'b1, 1'b0,
                32'h8000_0040, 32'h8000_0044, 32'h0000_0013);
    complete_retire();
    #2 rst = 1'b0;
    #1;
    checks++;
    if (wbu_send_valid !== 1'b0 || dnpc !== 32'h8000_0000 || wbu_state !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_send: sv=%b dnpc=%h st=%b, required 0 80000000 0", wbu_send_valid, dnpc, wbu_state);
    end
    csr_raddr = 2'd1;
    #1;
    checks++;
    if (rdata1 !== 32'd0 || csr_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_clears: x5=%h mtvec=%h, required 0 0", rdata1, csr_rdata);
    end
    m_mtvec = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    ifu_ready = 1'b1;
  endtask

  task automatic test_alu_retire();
    @(negedge clk);
    drive_instr(5'd5, 32'hDEAD_BEEF, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0,
                32'h8000_0000, 32'h8000_0004, 32'h0050_0293);
    complete_retire();
    raddr1 = 5'd5;
    #1;
    checks++;
    if (rdata1 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL alu_x5: got %h, required deadbeef", rdata1);
    end
  endtask

  task automatic test_x0_write();
    @(negedge clk);
    drive_instr(5'd0, 32'h0000_1234, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0,
                32'h8000_0004, 32'h8000_0008, 32'h0000_0013);
    complete_retire();
    raddr1 = 5'd0;
    raddr2 = 5'd5;
    #1;
    checks++;
    if (rdata1 !== 32'd0 || rdata2 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL x0_write: x0=%h x5=%h, required 0 deadbeef", rdata1, rdata2);
    end
  endtask

  task automatic test_csr_ecall();
    @(negedge clk);
    drive_instr(5'd0, 32'd0, 2'd1, 32'h8000_0100, 1'b0, 1'b1, 1'b0,
                32'h8000_0010, 32'h8000_0014, 32'h3050_1073);
    complete_retire();
    csr_raddr = 2'd1;
    #1;
    checks++;
    if (csr_rdata !== 32'h8000_0100) begin
      errors++;
      $display("FAIL csrw_mtvec: got %h, required 80000100", csr_rdata);
    end
    // ecall with a conflicting CSR write to mtvec and a GPR write to x3
    @(negedge clk);
    drive_instr(5'd3, 32'h0000_0055, 2'd1, 32'hBAD0_BAD0, 1'b1, 1'b1, 1'b1,
                32'h8000_0020, 32'h8000_0024, 32'h0000_0073);
    complete_retire();
    raddr1 = 5'd3;
    for (int c = 1; c < 4; c++) begin
      csr_raddr = c[1:0];
      #1;
      checks++;
      if (csr_rdata !== ((c == 1) ? 32'h8000_0100 : (c == 2) ? 32'h8000_0020 : 32'd11)) begin
        errors++;
        $display("FAIL ecall_csr%0d: got %h", c, csr_rdata);
      end
    end
    checks++;
    if (rdata1 !== 32'h0000_0055) begin
      errors++;
      $display("FAIL ecall_gpr: x3=%h, required 00000055", rdata1);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    ifu_ready = 1'b0;
    @(negedge clk);
    drive_instr(5'd7, 32'h0000_0777, 2'd0, 32'd0, 1'b1, 1'b0, 1'b0,
                32'h8000_0100, 32'h8000_0104, 32'h0070_0393);
    complete_retire();
    held = last_e.dnpc;
    // A second instruction offered while busy must be ignored
    wd = 32'h0000_0999; rd = 5'd8; reg_write_en = 1'b1; pc = 32'h8000_0200;
    wbu_receive_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (wbu_send_valid !== 1'b1 || dnpc !== held || wbu_state !== 1'b1 || commit_valid !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: sv=%b dnpc=%h st=%b cv=%b, required 1 %h 1 0", k, wbu_send_valid, dnpc, wbu_state, commit_valid, held);
      end
    end
    wbu_receive_valid = 1'b0;
    ifu_ready = 1'b1;
    @(negedge clk);
    raddr1 = 5'd8;
    raddr2 = 5'd7;
    #1;
    checks++;
    if (wbu_send_valid !== 1'b0 || wbu_state !== 1'b0 || rdata1 !== 32'd0 || rdata2 !== 32'h0000_0777) begin
      errors++;
      $display("FAIL bp_release: sv=%b st=%b x8=%h x7=%h, required 0 0 0 777", wbu_send_valid, wbu_state, rdata1, rdata2);
    end
  endtask

  task automatic test_back_to_back();
    int commits;
    commits = 0;
    ifu_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (commit_valid !== (k % 3 == 1)) begin
        errors++;
        $display("FAIL b2b_commit_c%0d: commit_valid=%b, required %b", k, commit_valid, (k % 3 == 1));
      end
      if (commit_valid) begin
        commits++;
        if (sb_q.size() != 0) last_e = sb_q.pop_front();
        checks++;
        if (commit_pc !== last_e.pc) begin
          errors++;
          $display("FAIL b2b_pc_c%0d: got %h, required %h", k, commit_pc, last_e.pc);
        end
      end
      if (k % 3 == 2) begin
        checks++;
        if (wbu_send_valid !== 1'b1 || dnpc !== last_e.dnpc) begin
          errors++;
          $display("FAIL b2b_send_c%0d: sv=%b dnpc=%h, required 1 %h", k, wbu_send_valid, dnpc, last_e.dnpc);
        end
      end
      if (k % 3 == 0 && k < 9) begin
        drive_instr(5'(10 + k / 3), 32'h0000_A000 + 32'(k), 2'd0, 32'd0, 1'b1, 1'b0, 1'b0,
                    32'h8000_0300 + 32'(4 * k), 32'h8000_0304 + 32'(4 * k), 32'h0000_0013 + 32'(k));
      end else begin
        wbu_receive_valid = 1'b0;
      end
    end
    checks++;
    if (commits != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d commits, required 3", commits);
    end
    for (int j = 0; j < 3; j++) begin
      raddr1 = 5'(10 + j);
      #1;
      checks++;
      if (rdata1 !== 32'h0000_A000 + 32'(3 * j)) begin
        errors++;
        $display("FAIL b2b_gpr%0d: got %h, required %h", j, rdata1, 32'h0000_A000 + 32'(3 * j));
      end
    end
  endtask

  initial begin
    errors = 0; checks = 0; m_mtvec = 32'd0;
    rst = 1'b0; wbu_receive_valid = 1'b0; wd = 32'd0; csr_wd = 32'd0;
    rd = 5'd0; csr_rd = 2'd0; reg_write_en = 1'b0; csreg_write_en = 1'b0;
    ecall = 1'b0; pc = 32'd0; pc_next = 32'd0; instruction = 32'd0;
    ifu_ready = 1'b1; raddr1 = 5'd0; raddr2 = 5'd0; csr_raddr = 2'd0;
    test_reset();
    test_alu_retire();
    test_x0_write();
    test_csr_ecall();
    test_backpressure();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
